// File: rtl/cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// cache_tag_ctrl
//
// Lookup/refill controller for the 4-entry tag CAM of a 2-way set-associative
// cache. A CPU block request is accepted in IDLE. Its tag is presented to the
// CAM match port, and hit/miss is resolved from the returned match bits,
// filtered by set and by the internal valid bits. A miss runs a main-memory
// refill handshake and then writes the tag into the chosen victim entry.
//
// CAM entry e maps to set e[1], way e[0].
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   cpu_req    request strobe, sampled only while cpu_ready=1
//   cpu_addr   {tag, set, offset}, latched on accept
//   cpu_ready  high exactly when the FSM is in IDLE
//   cpu_done   one-cycle completion pulse
//   cpu_hit    with cpu_done: 1 = hit, 0 = miss (refilled or timed out)
//   cpu_way    with cpu_done: CAM entry index = 2*set + way
//   cpu_err    with cpu_done: refill timed out
//   cam_argin  latched tag, driven to the CAM match port
//   cam_mbits  CAM match bits, combinational from cam_argin
//   cam_din    tag to write into the CAM
//   cam_addrs  CAM entry to write
//   cam_we     one-cycle CAM write strobe
//   mem_req    refill request, held until ack or timeout
//   mem_addr   refill block address {tag, set}
//   mem_ack    refill-complete pulse, honoured only in REFILL
// -----------------------------------------------------------------------------
module cache_tag_ctrl #(
  parameter int TAG_W       = 7,
  parameter int OFF_W       = 2,
  parameter int ADDR_W      = TAG_W + 1 + OFF_W,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic [1:0]        cpu_way,
  output logic              cpu_err,
  output logic [TAG_W-1:0]  cam_argin,
  input  logic [3:0]        cam_mbits,
  output logic [TAG_W-1:0]  cam_din,
  output logic [1:0]        cam_addrs,
  output logic              cam_we,
  output logic              mem_req,
  output logic [TAG_W:0]    mem_addr,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE
  } state_t;

  state_t state, state_nxt;

  // Request context latched on accept.
  logic [TAG_W-1:0] tag_q;
  logic             set_q;

  // Replacement bookkeeping. lru_q[s] names the way to replace next in set s.
  logic [3:0]       valid_q, valid_nxt;
  logic [1:0]       lru_q, lru_nxt;
  logic [1:0]       victim_q, victim_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // Next values of the registered CPU response.
  logic             done_nxt, hit_nxt, err_nxt;
  logic [1:0]       way_nxt;

  logic             accept;
  logic [3:0]       setmask;
  logic [3:0]       hitvec;
  logic             hit_any;
  logic [1:0]       hit_entry;
  logic             victim_way;
  logic [1:0]       miss_victim;
  logic             timeout;

  // Offset bits select a word inside the block; the tag controller ignores them.
  logic             unused_offset;
  assign unused_offset = ^cpu_addr[OFF_W-1:0];

  assign accept = (state == IDLE) && cpu_req;

  // ---------------------------------------------------------------------------
  // Lookup: match bits from entries outside the request's set, or from entries
  // never written since reset, are stale and must not count as hits.
  // ---------------------------------------------------------------------------
  assign setmask = set_q ? 4'b1100 : 4'b0011;
  assign hitvec  = cam_mbits & valid_q & setmask;
  assign hit_any = |hitvec;

  always_comb begin
    casez (hitvec)
      4'b???1: hit_entry = 2'd0;
      4'b??10: hit_entry = 2'd1;
      4'b?100: hit_entry = 2'd2;
      4'b1000: hit_entry = 2'd3;
      default: hit_entry = 2'd0;
    endcase
  end

  // Victim: fill an invalid way first (way0 before way1), otherwise the LRU way.
  always_comb begin
    if (!valid_q[{set_q, 1'b0}]) begin
      victim_way = 1'b0;
    end else if (!valid_q[{set_q, 1'b1}]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = lru_q[set_q];
    end
  end

  assign miss_victim = {set_q, victim_way};

  // The counter holds the number of REFILL cycles already completed, so the
  // MEM_TIMEOUT-th cycle without an ack is the last one.
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and next-value logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    valid_nxt  = valid_q;
    lru_nxt    = lru_q;
    victim_nxt = victim_q;
    cnt_nxt    = cnt_q;
    done_nxt   = 1'b0;
    hit_nxt    = 1'b0;
    err_nxt    = 1'b0;
    way_nxt    = cpu_way;

    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          state_nxt = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit_any) begin
          done_nxt       = 1'b1;
          hit_nxt        = 1'b1;
          way_nxt        = hit_entry;
          lru_nxt[set_q] = ~hit_entry[0];
          state_nxt      = IDLE;
        end else begin
          victim_nxt = miss_victim;
          cnt_nxt    = '0;
          state_nxt  = REFILL;
        end
      end

      REFILL: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        // An ack arriving in the timeout cycle still completes the refill.
        if (mem_ack) begin
          state_nxt = WRITE;
        end else if (timeout) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          way_nxt   = victim_q;
          state_nxt = IDLE;
        end
      end

      WRITE: begin
        valid_nxt[victim_q] = 1'b1;
        lru_nxt[set_q]      = ~victim_q[0];
        done_nxt            = 1'b1;
        way_nxt             = victim_q;
        state_nxt           = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and response registers
  // ---------------------------------------------------------------------------
  // NOTE: valid_q must be reset even though it behaves like a small array: the
  // CAM contents after power-up are garbage, and valid is what masks them out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q    <= '0;
      set_q    <= 1'b0;
      valid_q  <= '0;
      lru_q    <= '0;
      victim_q <= '0;
      cnt_q    <= '0;
      cpu_done <= 1'b0;
      cpu_hit  <= 1'b0;
      cpu_err  <= 1'b0;
      cpu_way  <= '0;
    end else begin
      if (accept) begin
        tag_q <= cpu_addr[ADDR_W-1:OFF_W+1];
        set_q <= cpu_addr[OFF_W];
      end
      valid_q  <= valid_nxt;
      lru_q    <= lru_nxt;
      victim_q <= victim_nxt;
      cnt_q    <= cnt_nxt;
      cpu_done <= done_nxt;
      cpu_hit  <= hit_nxt;
      cpu_err  <= err_nxt;
      cpu_way  <= way_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state. The handshake strobes come straight from the
  // state register, so reset removes them asynchronously.
  // ---------------------------------------------------------------------------
  assign cpu_ready = (state == IDLE);
  assign mem_req   = (state == REFILL);
  assign cam_we    = (state == WRITE);
  assign cam_argin = tag_q;
  assign cam_din   = tag_q;
  assign cam_addrs = victim_q;
  assign mem_addr  = {tag_q, set_q};

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_ctrl
//
// Directed testbench for cache_tag_ctrl (MEM_TIMEOUT = 8). The CAM match bits
// are driven directly by the stimulus so that valid and set filtering can be
// exercised independently of CAM contents. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_cache_tag_ctrl;

  localparam int TAG_W  = 7;
  localparam int OFF_W  = 2;
  localparam int ADDR_W = TAG_W + 1 + OFF_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_done;
  logic              cpu_hit;
  logic [1:0]        cpu_way;
  logic              cpu_err;
  logic [TAG_W-1:0]  cam_argin;
  logic [3:0]        cam_mbits;
  logic [TAG_W-1:0]  cam_din;
  logic [1:0]        cam_addrs;
  logic              cam_we;
  logic              mem_req;
  logic [TAG_W:0]    mem_addr;
  logic              mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  cache_tag_ctrl #(
    .TAG_W       (TAG_W),
    .OFF_W       (OFF_W),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .cpu_way   (cpu_way),
    .cpu_err   (cpu_err),
    .cam_argin (cam_argin),
    .cam_mbits (cam_mbits),
    .cam_din   (cam_din),
    .cam_addrs (cam_addrs),
    .cam_we    (cam_we),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a request: drive it, cross the accept edge, then release cpu_req.
  task automatic request(input logic [ADDR_W-1:0] addr, input logic [3:0] mbits);
    cpu_req   = 1'b1;
    cpu_addr  = addr;
    cam_mbits = mbits;
    tick();
    cpu_req   = 1'b0;
  endtask

  int req_cycles;
  int we_seen;
  int done_seen;
  logic err_seen;
  logic hit_seen;
  logic ready_seen;

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cam_mbits = 4'b0000;
    mem_ack   = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_ready",  cpu_ready, 1);
    check("rst_done",   cpu_done,  0);
    check("rst_memreq", mem_req,   0);
    check("rst_camwe",  cam_we,    0);
    check("rst_way",    cpu_way,   0);
    check("rst_argin",  cam_argin, 0);
    check("rst_memadr", mem_addr,  0);
    rst = 1'b0;
    tick();

    // ---------------- miss + refill, tag 54 set1 -> entry 2 ----------------
    request(10'h2A5, 4'b0000);
    check("t1_lookup_ready", cpu_ready, 0);
    check("t1_argin",        cam_argin, 7'h54);
    tick();                                   // REFILL cycle 1
    check("t1_memreq",  mem_req,  1);
    check("t1_memaddr", mem_addr, 8'hA9);
    tick();                                   // REFILL cycle 2
    check("t1_memreq2", mem_req, 1);
    tick();                                   // REFILL cycle 3
    mem_ack = 1'b1;
    tick();                                   // WRITE
    mem_ack = 1'b0;
    check("t1_memreq_drop", mem_req,   0);
    check("t1_camwe",       cam_we,    1);
    check("t1_camaddrs",    cam_addrs, 2);
    check("t1_camdin",      cam_din,   7'h54);
    check("t1_done_early",  cpu_done,  0);
    tick();                                   // back in IDLE
    check("t1_camwe_one",   cam_we,    0);
    check("t1_done",        cpu_done,  1);
    check("t1_hit",         cpu_hit,   0);
    check("t1_way",         cpu_way,   2);
    check("t1_err",         cpu_err,   0);
    check("t1_ready",       cpu_ready, 1);
    tick();
    check("t1_done_one",    cpu_done,  0);

    // ---------------- hit on entry 2; cpu_req during LOOKUP ignored ----------------
    request(10'h2A5, 4'b0100);
    cpu_req  = 1'b1;                          // must be ignored outside IDLE
    cpu_addr = 10'h114;
    check("t2_done_early", cpu_done, 0);
    check("t2_memreq_lk",  mem_req,  0);
    tick();                                   // 2 cycles after accept
    cpu_req = 1'b0;
    check("t2_done",   cpu_done,  1);
    check("t2_hit",    cpu_hit,   1);
    check("t2_way",    cpu_way,   2);
    check("t2_ready",  cpu_ready, 1);
    check("t2_memreq", mem_req,   0);
    check("t2_argin",  cam_argin, 7'h54);
    tick();
    check("t2_done_one", cpu_done, 0);

    // mem_ack while IDLE has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_ready", cpu_ready, 1);
    check("idle_ack_we",    cam_we,    0);

    // ---------------- set1 request, matches only in set0 / stale entry 3 ----------------
    // tag 11, set1: entry 2 valid, entry 3 invalid -> victim entry 3.
    request(10'h08C, 4'b1001);
    tick();
    check("t3_miss_memreq", mem_req,  1);
    check("t3_memaddr",     mem_addr, 8'h23);
    mem_ack = 1'b1;                           // ack in the first REFILL cycle
    tick();
    mem_ack = 1'b0;
    check("t3_camwe",    cam_we,    1);
    check("t3_camaddrs", cam_addrs, 3);
    check("t3_camdin",   cam_din,   7'h11);
    tick();
    check("t3_done", cpu_done, 1);
    check("t3_hit",  cpu_hit,  0);
    check("t3_way",  cpu_way,  3);
    tick();

    // ---------------- LRU: hit 54 (entry 2), then miss tag 22 -> entry 3 ----------------
    request(10'h2A5, 4'b0100);
    tick();
    check("t4_hit",     cpu_hit, 1);
    check("t4_hit_way", cpu_way, 2);
    tick();
    request(10'h114, 4'b0000);
    tick();
    check("t4_memreq", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t4_camwe",    cam_we,    1);
    check("t4_camaddrs", cam_addrs, 3);
    check("t4_camdin",   cam_din,   7'h22);
    tick();
    check("t4_done", cpu_done, 1);
    check("t4_way",  cpu_way,  3);
    tick();

    // ---------------- refill timeout (MEM_TIMEOUT = 8) ----------------
    request(10'h198, 4'b0000);               // tag 33, set0
    tick();                                   // REFILL cycle 1
    req_cycles = 0;
    we_seen    = 0;
    done_seen  = 0;
    err_seen   = 1'b0;
    hit_seen   = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) req_cycles++;
      if (cam_we) we_seen++;
      if (cpu_done) begin
        done_seen++;
        err_seen   = cpu_err;
        hit_seen   = cpu_hit;
        ready_seen = cpu_ready;
        break;
      end
      tick();
    end
    check("t5_req_cycles", req_cycles, 8);
    check("t5_done_seen",  done_seen,  1);
    check("t5_err",        err_seen,   1);
    check("t5_hit",        hit_seen,   0);
    check("t5_no_camwe",   we_seen,    0);
    check("t5_ready",      ready_seen, 1);
    tick();
    check("t5_err_one",    cpu_err,    0);

    // next request accepted normally: hit on entry 2
    request(10'h2A5, 4'b0100);
    tick();
    check("t5_next_done", cpu_done, 1);
    check("t5_next_hit",  cpu_hit,  1);
    check("t5_next_err",  cpu_err,  0);
    tick();

    // entry 0 stays invalid after the timeout: set0 match is not a hit
    request(10'h198, 4'b0001);
    tick();
    check("t5_valid_kept", mem_req, 1);

    // ---------------- reset in the middle of REFILL ----------------
    tick();
    rst = 1'b1;
    #1;
    check("t6_memreq_drop", mem_req,   0);
    check("t6_no_camwe",    cam_we,    0);
    check("t6_ready",       cpu_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_done", cpu_done, 0);

    // valid cleared: all-ones match bits still miss
    request(10'h2A5, 4'b1111);
    tick();
    check("t6_miss_done",   cpu_done, 0);
    check("t6_miss_memreq", mem_req,  1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t6_camaddrs", cam_addrs, 2);
    tick();
    check("t6_done", cpu_done, 1);
    check("t6_way",  cpu_way,  2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
